memory_game_core: RTL and testbench

Parametrised sequence-memory game engine for the lab board: it generates a pseudo-random light sequence, plays it back at a speed set by difficulty, checks the player's button presses, and grows the sequence by one entry per cleared level. It sits between the debounced button/switch inputs and the LED/seven-segment display drivers. It generalises the fixed 4-light, fixed-length game to N channels, a sequence that grows per level, difficulty-scaled playback speed and a win condition.

---
 rtl/memory_game_core.sv | 145 ++++++++++++++
 tb/tb_memory_game_core.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/memory_game_core.sv
// memory_game_core: sequence-memory game engine (LFSR-grown sequence, timed playback, press checking, levels).
// Define MEMGAME_TIMEOUT_EN to fail the player after TIMEOUT_TICKS idle ticks in INPUT.
module memory_game_core #(
   parameter int          NUM_LIGHTS      = 4,
   parameter int          SEQ_DEPTH       = 16,
   parameter int          TICK_BASE       = 1000,
   parameter int          TICK_STEP       = 200,
   parameter int          LEVELS_PER_DIFF = 4,
   parameter logic [15:0] SEED            = 16'hACE1,
   parameter int          TIMEOUT_TICKS   = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [NUM_LIGHTS-1:0] btn_i,
   output logic [NUM_LIGHTS-1:0] lights_o,
   output logic [7:0]            level_o,
   output logic [1:0]            difficulty_o,
   output logic [2:0]            phase_o,
   output logic                  game_over_o,
   output logic                  win_o
);
   localparam int IDX_W = $clog2(NUM_LIGHTS);
   localparam int PTR_W = $clog2(SEQ_DEPTH);
   localparam int CNT_W = $clog2(TICK_BASE);
   localparam int TN_W  = $clog2(TIMEOUT_TICKS + 2);
   localparam logic [2:0] IDLE = 3'd0, SHOW_ON = 3'd1, SHOW_GAP = 3'd2, INPUT = 3'd3,
                          GOOD = 3'd4, FAIL = 3'd5, WIN = 3'd6;

   logic [2:0]            state_q, state_d;
   logic [PTR_W-1:0]      ptr_q, ptr_d, wr_addr;
   logic [7:0]            level_q, level_d, lvl_m1;
   logic [1:0]            diff_q, diff_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d, period_m1;
   logic [TN_W-1:0]       tn_q, tn_d;
   logic [15:0]           lfsr_q;
   logic [NUM_LIGHTS-1:0] lights_q, lights_d, btn_q, btn_qq, rise;
   logic [IDX_W-1:0]      seq_q [SEQ_DEPTH];
   logic [IDX_W-1:0]      show_idx;
   logic                  wr_en, reload, tick_end, last, hit;

   assign rise     = btn_q & ~btn_qq;
   assign hit      = rise == (NUM_LIGHTS'(1) << seq_q[ptr_q]);
   assign tick_end = cnt_q == '0;
   assign last     = 8'(ptr_q) == level_q - 8'd1;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      level_d = level_q;
      tn_d    = tn_q;
      wr_en   = 1'b0;
      wr_addr = '0;
      reload  = 1'b0;
      case (state_q)
         IDLE, FAIL, WIN: if (start_i) begin
            state_d = SHOW_ON;
            ptr_d   = '0;
            level_d = 8'd1;
            wr_en   = 1'b1;
         end
         SHOW_ON: if (tick_end) state_d = SHOW_GAP;
         SHOW_GAP: if (tick_end) begin
            state_d = last ? INPUT : SHOW_ON;
            ptr_d   = last ? '0 : ptr_q + PTR_W'(1);
         end
         INPUT: begin
            if (rise != '0) begin
               if (!hit) state_d = FAIL;
               else if (last) state_d = GOOD;
               else begin
                  ptr_d  = ptr_q + PTR_W'(1);
                  tn_d   = '0;
                  reload = 1'b1;
               end
            end
`ifdef MEMGAME_TIMEOUT_EN
            else if (tick_end) begin
               if (tn_q == TN_W'(TIMEOUT_TICKS - 1)) state_d = FAIL;
               else tn_d = tn_q + TN_W'(1);
            end
`endif
         end
         GOOD: if (tick_end) begin
            if (tn_q != TN_W'(1)) tn_d = tn_q + TN_W'(1);
            else if (level_q == 8'(SEQ_DEPTH)) state_d = WIN;
            else begin
               state_d = SHOW_ON;
               level_d = level_q + 8'd1;
               ptr_d   = '0;
               wr_en   = 1'b1;
               wr_addr = PTR_W'(level_q);
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) tn_d = '0;
   end

   // Difficulty and tick period follow the next level so a new level starts at its own speed.
   assign lvl_m1    = level_d - 8'd1;
   assign diff_d    = level_d == 8'd0 ? 2'd0 :
                      (lvl_m1 / 8'(LEVELS_PER_DIFF)) > 8'd3 ? 2'd3 : 2'(lvl_m1 / 8'(LEVELS_PER_DIFF));
   assign period_m1 = CNT_W'(TICK_BASE - 1 - TICK_STEP * int'(diff_d));
   assign cnt_d     = (state_d != state_q || reload || tick_end) ? period_m1 : cnt_q - CNT_W'(1);
   assign show_idx  = (wr_en && wr_addr == ptr_d) ? lfsr_q[IDX_W-1:0] : seq_q[ptr_d];
   assign lights_d  = state_d == SHOW_ON ? NUM_LIGHTS'(1) << show_idx : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         level_q  <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         tn_q     <= '0;
         lfsr_q   <= SEED;
         lights_q <= '0;
         btn_q    <= '0;
         btn_qq   <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         level_q  <= level_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         tn_q     <= tn_d;
         lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
         lights_q <= lights_d;
         btn_q    <= btn_i;
         btn_qq   <= btn_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) seq_q[wr_addr] <= lfsr_q[IDX_W-1:0];
   end

   assign lights_o     = lights_q;
   assign level_o      = level_q;
   assign difficulty_o = diff_q;
   assign phase_o      = state_q;
   assign game_over_o  = state_q == FAIL;
   assign win_o        = state_q == WIN;
endmodule

// File: tb/tb_memory_game_core.sv
// tb_memory_game_core: directed vectors plus hand sequences for memory_game_core
// (4 lights, depth 4, period 10 dropping by 2 per difficulty, 2 levels per difficulty).
module tb_memory_game_core;
   localparam int B_NONE = 0, B_SEQ = 1, B_WRONG = 2;

   typedef struct {
      logic       st;
      int         bk;
      int         bi;
      int         n;
      int         cap;
      logic [2:0] ph;
      int         ls;
      logic [7:0] lv;
      logic [1:0] df;
      logic       go;
      logic       wn;
   } vec_t;

   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [3:0] btn = '0, lights;
   logic [7:0] level;
   logic [1:0] difficulty;
   logic [2:0] phase;
   logic       game_over, win;
   logic [15:0] lfsr_m;
   logic [1:0] s [4];
   vec_t       tv [22];
   int         n_cmp = 0, n_bad = 0;

   memory_game_core #(.NUM_LIGHTS(4), .SEQ_DEPTH(4), .TICK_BASE(10), .TICK_STEP(2),
                      .LEVELS_PER_DIFF(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .btn_i(btn), .lights_o(lights),
      .level_o(level), .difficulty_o(difficulty), .phase_o(phase),
      .game_over_o(game_over), .win_o(win));

   always #5 clk = ~clk;

   // Reference LFSR: reset and stepped with the DUT, so at a negedge it holds the value the next edge appends.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) lfsr_m <= 16'hACE1;
      else lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};

   function automatic logic [3:0] onehot(input logic [1:0] i);
      return 4'b0001 << i;
   endfunction

   function automatic logic [3:0] btn_of(input int bk, input int bi);
      return bk == B_SEQ ? onehot(s[bi]) : bk == B_WRONG ? onehot(s[bi] + 2'd1) : 4'b0000;
   endfunction

   function automatic logic [31:0] expv(input logic [3:0] l, input logic [7:0] lv, input logic [1:0] df,
                                        input logic [2:0] ph, input logic go, input logic wn);
      return 32'({l, lv, df, ph, go, wn});
   endfunction

   function automatic logic [31:0] obs();
      return 32'({lights, level, difficulty, phase, game_over, win});
   endfunction

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Starts on the negedge just after SHOW_ON entry of level lv; ends just after leaving GOOD.
   task automatic play_level(input int lv);
      int p = lv >= 3 ? 8 : 10;
      logic [1:0] df = lv >= 3 ? 2'd1 : 2'd0;
      check($sformatf("play_on_l%0d", lv), obs(), expv(onehot(s[0]), 8'(lv), df, 3'd1, 1'b0, 1'b0));
      step(p - 1);
      check($sformatf("on_len_l%0d", lv), 32'(phase), 32'(1));
      step(1);
      check($sformatf("gap_l%0d", lv), 32'(phase), 32'(2));
      step(2 * lv * p - p);
      check($sformatf("input_l%0d", lv), 32'(phase), 32'(3));
      for (int k = 0; k < lv; k++) begin
         btn = onehot(s[k]);
         step(2);
         btn = '0;
         check($sformatf("press_l%0d_k%0d", lv, k), 32'(phase), k == lv - 1 ? 32'(4) : 32'(3));
         if (k < lv - 1) step(1);
      end
      step(2 * p - 1);
      check($sformatf("good_len_l%0d", lv), 32'(phase), 32'(4));
      if (lv < 4) s[lv] = lfsr_m[1:0];
      step(1);
   endtask

   initial begin
      tv[0]  = '{1'b0, B_NONE,  0,  1, -1, 3'd0, -1, 8'd0, 2'd0, 1'b0, 1'b0};
      tv[1]  = '{1'b1, B_NONE,  0,  1,  0, 3'd1,  0, 8'd1, 2'd0, 1'b0, 1'b0};
      tv[2]  = '{1'b0, B_NONE,  0,  9, -1, 3'd1,  0, 8'd1, 2'd0, 1'b0, 1'b0};
      tv[3]  = '{1'b0, B_NONE,  0,  1, -1, 3'd2, -1, 8'd1, 2'd0, 1'b0, 1'b0};
      tv[4]  = '{1'b0, B_NONE,  0,  9, -1, 3'd2, -1, 8'd1, 2'd0, 1'b0, 1'b0};
      tv[5]  = '{1'b0, B_NONE,  0,  1, -1, 3'd3, -1, 8'd1, 2'd0, 1'b0, 1'b0};
      tv[6]  = '{1'b0, B_SEQ,   0,  1, -1, 3'd3, -1, 8'd1, 2'd0, 1'b0, 1'b0};
      tv[7]  = '{1'b0, B_SEQ,   0,  1, -1, 3'd4, -1, 8'd1, 2'd0, 1'b0, 1'b0};
      tv[8]  = '{1'b0, B_NONE,  0, 19, -1, 3'd4, -1, 8'd1, 2'd0, 1'b0, 1'b0};
      tv[9]  = '{1'b0, B_NONE,  0,  1,  1, 3'd1,  0, 8'd2, 2'd0, 1'b0, 1'b0};
      tv[10] = '{1'b0, B_NONE,  0,  9, -1, 3'd1,  0, 8'd2, 2'd0, 1'b0, 1'b0};
      tv[11] = '{1'b0, B_NONE,  0,  1, -1, 3'd2, -1, 8'd2, 2'd0, 1'b0, 1'b0};
      tv[12] = '{1'b0, B_NONE,  0, 10, -1, 3'd1,  1, 8'd2, 2'd0, 1'b0, 1'b0};
      tv[13] = '{1'b0, B_NONE,  0, 10, -1, 3'd2, -1, 8'd2, 2'd0, 1'b0, 1'b0};
      tv[14] = '{1'b0, B_NONE,  0, 10, -1, 3'd3, -1, 8'd2, 2'd0, 1'b0, 1'b0};
      tv[15] = '{1'b0, B_SEQ,   0,  2, -1, 3'd3, -1, 8'd2, 2'd0, 1'b0, 1'b0};
      tv[16] = '{1'b0, B_NONE,  0,  1, -1, 3'd3, -1, 8'd2, 2'd0, 1'b0, 1'b0};
      tv[17] = '{1'b0, B_WRONG, 1,  2, -1, 3'd5, -1, 8'd2, 2'd0, 1'b1, 1'b0};
      tv[18] = '{1'b0, B_NONE,  0,  5, -1, 3'd5, -1, 8'd2, 2'd0, 1'b1, 1'b0};
      tv[19] = '{1'b1, B_NONE,  0,  1,  0, 3'd1,  0, 8'd1, 2'd0, 1'b0, 1'b0};
      tv[20] = '{1'b0, B_NONE,  0, 19, -1, 3'd2, -1, 8'd1, 2'd0, 1'b0, 1'b0};
      tv[21] = '{1'b0, B_NONE,  0,  1, -1, 3'd3, -1, 8'd1, 2'd0, 1'b0, 1'b0};

      step(2);
      rst_n = 1'b1;
      for (int i = 0; i < 22; i++) begin
         start = tv[i].st;
         btn   = btn_of(tv[i].bk, tv[i].bi);
         if (tv[i].cap >= 0) s[tv[i].cap] = lfsr_m[1:0];
         step(tv[i].n);
         check($sformatf("vec%0d", i), obs(),
               expv(tv[i].ls < 0 ? 4'b0000 : onehot(s[tv[i].ls]), tv[i].lv, tv[i].df, tv[i].ph,
                    tv[i].go, tv[i].wn));
      end

      // Two rising edges in one cycle, even if one is correct, is a failure.
      btn = onehot(s[0]) | onehot(s[0] ^ 2'd1);
      step(2);
      btn = '0;
      check("two_btn", obs(), expv(4'b0000, 8'd1, 2'd0, 3'd5, 1'b1, 1'b0));

      // A button held from before playback never registers as a press.
      start = 1'b1;
      s[0]  = lfsr_m[1:0];
      btn   = onehot(lfsr_m[1:0]);
      step(1);
      start = 1'b0;
      step(20);
      check("held_input", obs(), expv(4'b0000, 8'd1, 2'd0, 3'd3, 1'b0, 1'b0));
      step(5);
      check("held_ignored", 32'(phase), 32'(3));
      btn = '0;
      step(1);
      btn = onehot(s[0]);
      step(2);
      btn = '0;
      check("press_after_release", 32'(phase), 32'(4));
      step(19);
      s[1] = lfsr_m[1:0];
      step(1);
      play_level(2);
      play_level(3);
      play_level(4);
      check("win", obs(), expv(4'b0000, 8'd4, 2'd1, 3'd6, 1'b0, 1'b1));
      step(5);
      check("win_hold", obs(), expv(4'b0000, 8'd4, 2'd1, 3'd6, 1'b0, 1'b1));

      // Reset in the middle of SHOW_ON clears outputs without waiting for a clock edge.
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(3);
      check("pre_reset_on", 32'(phase), 32'(1));
      #2 rst_n = 1'b0;
      #1 check("async_reset", obs(), expv(4'b0000, 8'd0, 2'd0, 3'd0, 1'b0, 1'b0));
      @(negedge clk);
      rst_n = 1'b1;
      step(2);
      check("idle_after_reset", obs(), expv(4'b0000, 8'd0, 2'd0, 3'd0, 1'b0, 1'b0));

      start = 1'b1;
      step(1);
      start = 1'b0;
      step(20);
      check("input_wait", 32'(phase), 32'(3));
`ifdef MEMGAME_TIMEOUT_EN
      step(79);
      check("timeout_edge", 32'(phase), 32'(3));
      step(1);
      check("timeout_fail", obs(), expv(4'b0000, 8'd1, 2'd0, 3'd5, 1'b1, 1'b0));
`else
      step(100);
      check("no_timeout", obs(), expv(4'b0000, 8'd1, 2'd0, 3'd3, 1'b0, 1'b0));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
